csa_accum_ctrl: RTL and testbench

//  Sequencer for the carry-save adder datapath. It accepts a burst of W-bit operands on a valid/ready stream.

---
 rtl/csa_ctrl_pkg.sv | 30 +++
 rtl/csa_3to2.sv | 32 +++
 rtl/csa_accum_ctrl.sv | 173 +++++++++++++++++
 tb/tb_csa_accum_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// csa_ctrl_pkg
//   Shared types and constants for the carry-save accumulator controller.
//   - csa_state_t : sequencer states
//   - CSA_W_DEF / CSA_MAX_OPS_DEF : default operand width and burst length
//   - cnt_width() : width of an operand counter able to hold max_ops
//   - acc_width() : accumulator width; widened when CSA_OVF_EN is defined
//                   so the true sum never wraps inside the accumulator
// Configuration macro: CSA_OVF_EN
// ----------------------------------------------------------------------------
package csa_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} csa_state_t;

    localparam int CSA_W_DEF       = 32;
    localparam int CSA_MAX_OPS_DEF = 16;

    function automatic int cnt_width(input int max_ops);
        return $clog2(max_ops + 1);
    endfunction

    function automatic int acc_width(input int w, input int max_ops);
`ifdef CSA_OVF_EN
        return w + $clog2(max_ops);
`else
        return w;
`endif
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// ----------------------------------------------------------------------------
// csa_3to2
//   Combinational N-bit 3:2 compressor (carry-save adder row).
//   Ports:
//     a, b, c : in  [N-1:0] three addends
//     s       : out [N-1:0] bitwise sum a^b^c
//     cy      : out [N-1:0] majority carries shifted left by one; the carry
//                           out of bit N-1 is dropped (result mod 2^N)
//   Requires N >= 2.
// ----------------------------------------------------------------------------
module csa_3to2 #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] s,
    output logic [N-1:0] cy
);

    // Only the low N-1 majority bits survive the shift, so the top one is
    // never formed.
    logic [N-2:0] w_maj;

    assign w_maj = (a[N-2:0] & b[N-2:0])
                 | (a[N-2:0] & c[N-2:0])
                 | (b[N-2:0] & c[N-2:0]);

    assign s  = a ^ b ^ c;
    assign cy = {w_maj, 1'b0};

endmodule

// File: rtl/csa_accum_ctrl.sv
// ----------------------------------------------------------------------------
// csa_accum_ctrl
//   Accepts a burst of unsigned W-bit operands on a valid/ready stream, folds
//   each one into a redundant (sum, carry) accumulator through a 3:2
//   compressor, resolves the accumulator with one carry-propagate add at the
//   end of the burst and holds the result until the consumer takes it.
//   Reaching MAX_OPS operands ends the burst as if in_last had been set.
//   Ports:
//     clk       : in       clock, all state on the rising edge
//     rst       : in       synchronous active-high reset
//     in_valid  : in       operand beat valid
//     in_ready  : out      beat can be accepted (IDLE/ACCUM and no abort)
//     in_data   : in  [W]  operand
//     in_last   : in       beat closes the burst
//     abort     : in       discard the partial burst (IDLE/ACCUM only)
//     out_valid : out      result valid
//     out_ready : in       consumer takes the result
//     out_data  : out [W]  burst sum mod 2^W
//     out_cnt   : out [CW] operands in the burst
//     out_ovf   : out      true sum needed more than W bits
//   Configuration macro: CSA_OVF_EN -- widens the accumulator and drives
//   out_ovf; when undefined out_ovf is constant 0.
// ----------------------------------------------------------------------------
module csa_accum_ctrl
    import csa_ctrl_pkg::*;
#(
    parameter  int W       = CSA_W_DEF,
    parameter  int MAX_OPS = CSA_MAX_OPS_DEF,
    localparam int CW      = cnt_width(MAX_OPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_cnt,
    output logic          out_ovf
);

    localparam int AW = acc_width(W, MAX_OPS);

    csa_state_t    r_state;
    csa_state_t    w_next_state;
    logic [AW-1:0] r_sum;
    logic [AW-1:0] r_carry;
    logic [CW-1:0] r_op_cnt;
    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic [CW-1:0] r_out_cnt;

    logic [AW-1:0] w_in_ext;
    logic [AW-1:0] w_csa_s;
    logic [AW-1:0] w_csa_cy;
    logic [AW-1:0] w_final;
    logic          w_accept;
    logic          w_last;

    assign in_ready = ((r_state == IDLE) || (r_state == ACCUM)) && !abort;
    assign w_accept = in_valid && in_ready;
    // Hitting the operand limit closes the burst exactly like in_last.
    assign w_last   = in_last || ((r_op_cnt + CW'(1)) == CW'(MAX_OPS));
    assign w_in_ext = AW'(in_data);
    assign w_final  = r_sum + r_carry;

    csa_3to2 #(.N(AW)) u_csa (
        .a  (r_sum),
        .b  (r_carry),
        .c  (w_in_ext),
        .s  (w_csa_s),
        .cy (w_csa_cy)
    );

    // NOTE: every combinational output gets a default before the case so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, ACCUM: begin
                if (abort)
                    w_next_state = IDLE;
                else if (w_accept)
                    w_next_state = w_last ? RESOLVE : ACCUM;
            end
            RESOLVE: w_next_state = DONE;
            DONE: begin
                if (out_ready)
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // Result registers are reset too: out_data/out_cnt must read 0 until the
    // first result, not whatever the flops powered up with.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum       <= '0;
            r_carry     <= '0;
            r_op_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (abort) begin
                        r_sum    <= '0;
                        r_carry  <= '0;
                        r_op_cnt <= '0;
                    end else if (w_accept) begin
                        if (r_state == IDLE) begin
                            r_sum   <= w_in_ext;
                            r_carry <= '0;
                        end else begin
                            r_sum   <= w_csa_s;
                            r_carry <= w_csa_cy;
                        end
                        r_op_cnt <= r_op_cnt + CW'(1);
                    end
                end
                RESOLVE: begin
                    r_out_data  <= w_final[W-1:0];
                    r_out_cnt   <= r_op_cnt;
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_sum       <= '0;
                        r_carry     <= '0;
                        r_op_cnt    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CSA_OVF_EN
    logic r_out_ovf;

    // Any bit above W in the widened sum means the true total did not fit.
    always_ff @(posedge clk) begin
        if (rst)
            r_out_ovf <= 1'b0;
        else if (r_state == RESOLVE)
            r_out_ovf <= |w_final[AW-1:W];
    end

    assign out_ovf = r_out_ovf;
`else
    assign out_ovf = 1'b0;
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// ----------------------------------------------------------------------------
// tb_csa_accum_ctrl
//   Self-checking bench for csa_accum_ctrl. A burst-level model (running
//   64-bit sum and operand count) predicts each result; a monitor process
//   drives out_ready and compares every result taken by the consumer.
// ----------------------------------------------------------------------------
module tb_csa_accum_ctrl;

    localparam int W       = 32;
    localparam int MAX_OPS = 16;
    localparam int CW      = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          abort;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_cnt;
    logic          out_ovf;

    always #5 clk = ~clk;

    csa_accum_ctrl #(.W(W), .MAX_OPS(MAX_OPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- burst-level reference model ----------------
    typedef struct packed {
        logic [W-1:0]  data;
        logic [CW-1:0] cnt;
        logic          ovf;
    } res_t;

    res_t            exp_q[$];
    longint unsigned m_sum      = 0;
    int              m_cnt      = 0;
    bit              just_ended = 1'b0;

    task automatic model_beat(input logic [W-1:0] d, input bit last);
        res_t r;
        m_sum += longint'(d);
        m_cnt++;
        if (last || m_cnt == MAX_OPS) begin
            r.data = m_sum[W-1:0];
            r.cnt  = m_cnt[CW-1:0];
`ifdef CSA_OVF_EN
            r.ovf  = (m_sum >> W) != 0;
`else
            r.ovf  = 1'b0;
`endif
            exp_q.push_back(r);
            m_sum      = 0;
            m_cnt      = 0;
            just_ended = 1'b1;
        end
    endtask

    task automatic model_drop();
        m_sum = 0;
        m_cnt = 0;
    endtask

    // ---------------- result monitor / consumer ----------------
    bit            rand_ready   = 1'b0;
    bit            forced_ready = 1'b0;
    bit            hold_prev    = 1'b0;
    logic [W-1:0]  hold_data;
    logic [CW-1:0] hold_cnt;
    logic          hold_ovf;

    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
            #2;
            if (out_valid === 1'b1) begin
                check("busy_in_ready", in_ready, 0);
                if (hold_prev) begin
                    check("hold_data", out_data, hold_data);
                    check("hold_cnt",  out_cnt,  hold_cnt);
                    check("hold_ovf",  out_ovf,  hold_ovf);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", out_valid, 0);
                    end else begin
                        r = exp_q.pop_front();
                        check("out_data", out_data, r.data);
                        check("out_cnt",  out_cnt,  r.cnt);
                        check("out_ovf",  out_ovf,  r.ovf);
                    end
                    hold_prev = 1'b0;
                end else begin
                    hold_prev = 1'b1;
                    hold_data = out_data;
                    hold_cnt  = out_cnt;
                    hold_ovf  = out_ovf;
                end
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_beat(input logic [W-1:0] d, input bit last, output int stall);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        abort    = 1'b0;
        stall    = 0;
        #1;
        while (in_ready !== 1'b1) begin
            if (stall >= 500) begin
                check("in_ready_timeout", in_ready, 1);
                break;
            end
            @(negedge clk);
            #1;
            stall++;
        end
        model_beat(d, last);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        check("drain", exp_q.size(), 0);
        idle(1);
    endtask

    task automatic check_quiet(input string tag, input int n);
        repeat (n) begin
            @(negedge clk);
            #3;
            check(tag, out_valid, 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          stall;
        int          cyc;
        logic [W-1:0] d;
        int          len;
        bit          mid;
        bit          je;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        abort    = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_cnt",   out_cnt,   0);
        check("rst_out_ovf",   out_ovf,   0);
        check("rst_in_ready",  in_ready,  1);
        @(negedge clk);
        rst = 1'b0;

        // 1: single beat, latency of two edges
        forced_ready = 1'b1;
        drive_beat(32'h0000_0005, 1'b1, stall);
        check("t1_stall", stall, 0);
        idle(1);
        #1;
        check("t1_valid_edge1", out_valid, 0);
        @(negedge clk);
        #1;
        check("t1_valid_edge2", out_valid, 1);
        wait_drain(20);

        // 2: four back-to-back beats
        for (int i = 1; i <= 4; i++) begin
            drive_beat(W'(i), i == 4, stall);
            check("t2_stall", stall, 0);
        end
        idle(1);
        wait_drain(20);

        // 3: wrap past W bits
        drive_beat(32'hFFFF_FFFF, 1'b0, stall);
        drive_beat(32'h0000_0002, 1'b1, stall);
        idle(1);
        wait_drain(20);

        // 4: operand limit forces the end of the burst
        rand_ready = 1'b1;
        for (int i = 0; i < MAX_OPS; i++) begin
            drive_beat(32'h1, 1'b0, stall);
            check("t4_stall", stall, 0);
        end
        drive_beat(32'h1, 1'b0, stall);
        check("t4_17th_stalled", stall >= 2, 1);
        drive_beat(32'h4, 1'b1, stall);
        check("t4_next_stall", stall, 0);
        idle(1);
        wait_drain(100);

        // 5: consumer stall in DONE
        rand_ready   = 1'b0;
        forced_ready = 1'b0;
        drive_beat(32'h10, 1'b0, stall);
        drive_beat(32'h20, 1'b0, stall);
        drive_beat(32'h30, 1'b1, stall);
        idle(1);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            #3;
            cyc++;
        end
        check("t5_valid", out_valid, 1);
        repeat (5) @(negedge clk);
        forced_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #3;
        check("t5_idle_valid", out_valid, 0);
        check("t5_idle_ready", in_ready,  1);
        wait_drain(20);

        // 6a: abort drops the partial burst and the concurrent beat
        drive_beat(32'h3, 1'b0, stall);
        drive_beat(32'h4, 1'b0, stall);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h9;
        abort    = 1'b1;
        #1;
        check("t6_abort_ready", in_ready, 0);
        model_drop();
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check_quiet("t6_abort_quiet", 3);
        drive_beat(32'h7, 1'b1, stall);
        idle(1);
        wait_drain(20);

        // 6b: same with reset
        drive_beat(32'h3, 1'b0, stall);
        drive_beat(32'h4, 1'b0, stall);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h9;
        rst      = 1'b1;
        model_drop();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check_quiet("t6_rst_quiet", 3);
        drive_beat(32'h7, 1'b1, stall);
        idle(1);
        wait_drain(20);

        // randomized bursts with gaps and consumer back-pressure
        rand_ready = 1'b1;
        just_ended = 1'b0;
        for (int b = 0; b < 40; b++) begin
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    idle($urandom_range(1, 2));
                    just_ended = 1'b0;
                end
                case ($urandom_range(0, 2))
                    0:       d = $urandom;
                    1:       d = 32'hFFFF_FF00 | W'($urandom_range(0, 255));
                    default: d = W'($urandom_range(0, 255));
                endcase
                mid        = (m_cnt > 0);
                je         = just_ended;
                just_ended = 1'b0;
                drive_beat(d, i == len - 1, stall);
                if (mid)
                    check("rnd_mid_stall", stall, 0);
                if (je)
                    check("rnd_gap_stall", stall >= 2, 1);
            end
        end
        idle(1);
        wait_drain(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
